fifo_dualport: RTL and testbench

FIFO_DUALPORT -- requirements
Module: fifo_dualport

---
 rtl/fifo_dualport.sv | 111 +++++++++++
 tb/tb_fifo_dualport.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_dualport.sv
// rtl/fifo_dualport.sv - show-ahead single-clock FIFO on a dual-port array with registered head word
//
// Optional feature macro: FIFO_DUALPORT_LEVEL_EN (adds level_o occupancy output)
//
// Ports:
//   clk_i    in   1      clock, rising-edge
//   rst_ni   in   1      asynchronous active-low reset
//   wr_en_i  in   1      write request, data_i captured on the same edge
//   rd_en_i  in   1      read request, pops the word shown on data_o
//   data_i   in   WIDTH  write data
//   data_o   out  WIDTH  head-of-queue word, valid while empty_o=0
//   empty_o  out  1      no word presented on data_o
//   full_o   out  1      occupancy equals DEPTH
//   level_o  out  clog2(DEPTH+1)  occupancy (FIFO_DUALPORT_LEVEL_EN only)
//
// Words flow array -> ram_q (synchronous read stage) -> data_o (head register).
// A word is "unfetched" while it only lives in the array.

module fifo_dualport #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 10
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       wr_en_i,
   input  logic                       rd_en_i,
   input  logic [WIDTH-1:0]           data_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       empty_o,
`ifdef FIFO_DUALPORT_LEVEL_EN
   output logic [$clog2(DEPTH+1)-1:0] level_o,
`endif
   output logic                       full_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_next;
   logic [CW-1:0]    unfetched;
   logic [WIDTH-1:0] ram_q;
   logic             ram_valid;
   logic             out_valid;
   logic             rd_acc;
   logic             wr_acc;
   logic             out_load;
   logic             stage_free;
   logic             fetch;
   logic             bypass;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      out_valid  = ~empty_o;
      rd_acc     = rd_en_i & out_valid;
      wr_acc     = wr_en_i & (~full_o | rd_acc);
      count_next = count + CW'(wr_acc) - CW'(rd_acc);
      unfetched  = count - CW'(ram_valid) - CW'(out_valid);
      // Head register refills from the read stage whenever it is free or being popped.
      out_load   = ram_valid & (~out_valid | rd_acc);
      stage_free = ~ram_valid | out_load;
      fetch      = (unfetched != '0) & stage_free;
      // With nothing left in the array, a new word skips the array read and lands
      // straight in the read stage. This keeps "read stage empty" implying "array
      // empty", so a pop never leaves a bubble while more than one word is held.
      bypass     = wr_acc & (unfetched == '0) & stage_free;
   end

   // Array write port; the array is not reset, stale contents are never presented.
   always_ff @(posedge clk_i) begin
      if (wr_acc) mem[wr_ptr] <= data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         ram_q     <= '0;
         ram_valid <= 1'b0;
         data_o    <= '0;
         empty_o   <= 1'b1;
         full_o    <= 1'b0;
      end else begin
         count  <= count_next;
         full_o <= (count_next == CW'(DEPTH));
         if (wr_acc) wr_ptr <= inc(wr_ptr);
         // Fetch never aliases the write address: unfetched < DEPTH whenever fetch is set.
         if (fetch | bypass) rd_ptr <= inc(rd_ptr);
         if (fetch) begin
            ram_q <= mem[rd_ptr];
         end else if (bypass) begin
            ram_q <= data_i;
         end
         ram_valid <= fetch | bypass | (ram_valid & ~out_load);
         if (out_load) data_o <= ram_q;
         empty_o <= ~(out_load | (out_valid & ~rd_acc));
      end
   end

`ifdef FIFO_DUALPORT_LEVEL_EN
   assign level_o = count;
`endif

endmodule

// File: tb/tb_fifo_dualport.sv
// tb/tb_fifo_dualport.sv - self-checking bench for fifo_dualport

module tb_fifo_dualport;

   localparam int WIDTH = 8;
   localparam int DEPTH = 10;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             wr_en = 1'b0;
   logic             rd_en = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic [WIDTH-1:0] dout;
   logic             empty;
   logic             full;
`ifdef FIFO_DUALPORT_LEVEL_EN
   logic [CW-1:0]    level;
`endif

   fifo_dualport #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .wr_en_i (wr_en),
      .rd_en_i (rd_en),
      .data_i  (din),
      .data_o  (dout),
      .empty_o (empty),
`ifdef FIFO_DUALPORT_LEVEL_EN
      .level_o (level),
`endif
      .full_o  (full)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      logic [WIDTH-1:0] d;
      int               t;
   } ent_t;
   ent_t q[$];

   typedef struct {
      bit               w;
      bit               r;
      logic [WIDTH-1:0] d;
      bit               ce;
      bit               e;
      bit               f;
      bit               cd;
      logic [WIDTH-1:0] data;
   } vec_t;
   vec_t vt[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference rules: full exactly at DEPTH words; nothing shown when empty;
   // any shown word is the oldest; oldest word must be shown once written 2+ edges ago.
   task automatic check_model();
      check("full", full, q.size() == DEPTH);
`ifdef FIFO_DUALPORT_LEVEL_EN
      check("level", level, q.size());
`endif
      if (q.size() == 0) begin
         check("empty_when_none", empty, 1);
      end else begin
         if (cyc - q[0].t >= 3) check("head_late", empty, 0);
         if (!empty) check("head_data", dout, q[0].d);
      end
   endtask

   task automatic step(input bit w, input bit r, input logic [WIDTH-1:0] d,
                       output bit wa, output bit ra);
      ent_t e;
      wr_en = w;
      rd_en = r;
      din   = d;
      ra = r && !empty;
      wa = w && (q.size() < DEPTH || ra);
      if (ra && q.size() > 0) begin
         check("pop_data", dout, q[0].d);
         e = q.pop_front();
      end
      if (wa) begin
         e.d = d;
         e.t = cyc;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      cyc++;
      wr_en = 1'b0;
      rd_en = 1'b0;
      check_model();
   endtask

   task automatic add(input bit w, input bit r, input logic [WIDTH-1:0] d, input bit ce,
                      input bit e, input bit f, input bit cd, input logic [WIDTH-1:0] data);
      vec_t v;
      v.w = w; v.r = r; v.d = d; v.ce = ce; v.e = e; v.f = f; v.cd = cd; v.data = data;
      vt.push_back(v);
   endtask

   initial begin
      bit wa, ra;
      int sent, got, wg, rg, budget;
      bit w, r;
      logic [WIDTH-1:0] d;

      // Stimulus table: one row per edge, expectations observed after that edge.
      add(1, 0, 8'h11, 0, 0, 0, 0, 8'h00);
      add(1, 0, 8'h22, 0, 0, 0, 0, 8'h00);
      add(1, 0, 8'h33, 1, 0, 0, 1, 8'h11);
      add(0, 1, 8'h00, 1, 0, 0, 1, 8'h22);
      add(0, 1, 8'h00, 1, 0, 0, 1, 8'h33);
      add(0, 1, 8'h00, 1, 1, 0, 0, 8'h00);
      add(0, 0, 8'h00, 1, 1, 0, 0, 8'h00);
      for (int i = 0; i < 10; i++)
         add(1, 0, 8'(i), i >= 2, 0, i == 9, i >= 2, 8'h00);
      add(1, 0, 8'hAA, 1, 0, 1, 1, 8'h00);
      add(1, 1, 8'h55, 1, 0, 1, 1, 8'h01);
      for (int k = 1; k <= 9; k++)
         add(0, 1, 8'h00, 1, 0, 0, 1, (k < 9) ? 8'(k + 1) : 8'h55);
      add(0, 1, 8'h00, 1, 1, 0, 0, 8'h00);
      add(1, 1, 8'h7E, 0, 0, 0, 0, 8'h00);
      add(0, 0, 8'h00, 1, 0, 0, 1, 8'h7E);
      add(0, 1, 8'h00, 1, 1, 0, 0, 8'h00);

      // Asynchronous reset, checked before any clock edge.
      #1 rst_n = 1'b0;
      #1;
      check("reset_empty", empty, 1);
      check("reset_full", full, 0);
      check("reset_data", dout, 0);
`ifdef FIFO_DUALPORT_LEVEL_EN
      check("reset_level", level, 0);
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vt.size(); i++) begin
         step(vt[i].w, vt[i].r, vt[i].d, wa, ra);
         check($sformatf("v%0d_full", i), full, vt[i].f);
         if (vt[i].ce) check($sformatf("v%0d_empty", i), empty, vt[i].e);
         if (vt[i].cd) check($sformatf("v%0d_data", i), dout, vt[i].data);
      end
      check("table_drained", q.size(), 0);

      // Reset mid-stream with 5 words held.
      for (int i = 0; i < 5; i++) step(1, 0, 8'(8'hA0 + i), wa, ra);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_empty", empty, 1);
      check("midrst_full", full, 0);
      check("midrst_data", dout, 0);
      q.delete();
      @(posedge clk);
      #1;
      check("midrst_hold_empty", empty, 1);
      rst_n = 1'b1;
      step(1, 0, 8'h01, wa, ra);
      step(0, 0, 8'h00, wa, ra);
      step(0, 0, 8'h00, wa, ra);
      check("postrst_empty", empty, 0);
      check("postrst_data", dout, 8'h01);
      step(0, 1, 8'h00, wa, ra);
      check("postrst_drained", empty, 1);

      // Randomised traffic, 1000 words, 0..10 idle cycles on each side.
      sent = 0; got = 0; wg = 0; rg = 0; budget = 0;
      while (got < 1000 && budget < 40000) begin
         w = (sent < 1000) && (wg == 0);
         r = (rg == 0);
         d = WIDTH'($urandom);
         step(w, r, d, wa, ra);
         if (wa) begin
            sent++;
            wg = $urandom_range(0, 10);
         end else if (wg > 0) begin
            wg--;
         end
         if (ra) begin
            got++;
            rg = $urandom_range(0, 10);
         end else if (rg > 0) begin
            rg--;
         end
         budget++;
      end
      check("random_words_out", got, 1000);
      check("random_words_in", sent, 1000);
      check("random_drained", empty, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
